// File: rtl/lin_frame_rx.sv
// LIN frame decoder (break/sync/PID/data/checksum); result and error pulses appear one cycle after the deciding stop-bit sample.
// No backpressure, listen-only; define LIN_ENHANCED_CHECKSUM_EN to seed the checksum with the protected PID.
module lin_frame_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int BREAK_BITS   = 13,
    parameter int DATA_BYTES   = 8,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        sdi,
    output logic [5:0]  pid_out,
    output logic        pid_valid,
    output logic [63:0] data_out,
    output logic        frame_valid,
    output logic        sync_err,
    output logic        parity_err,
    output logic        checksum_err,
    output logic        framing_err,
    output logic        timeout_err,
    output logic        rx_busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int BCW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BKW      = $clog2(BREAK_BITS + 1);
    localparam int TOW      = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_BREAK, S_WAIT_START, S_SHIFT, S_STOP} state_t;
    typedef enum logic [1:0] {F_SYNC, F_PID, F_DATA, F_CHECKSUM} field_t;

    state_t      state, state_nxt;
    field_t      field, field_nxt;
    logic        sdi_prev;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt, cnt_cur;
    logic [BKW-1:0] brk_cnt, brk_cnt_nxt;
    logic [TOW-1:0] to_cnt, to_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [2:0]  byte_idx, byte_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  sum, sum_nxt;
    logic [63:0] data_buf, data_buf_nxt;
    logic [5:0]  pid_nxt;
    logic [63:0] data_nxt;
    logic        pid_valid_nxt, frame_valid_nxt, sync_err_nxt, parity_err_nxt;
    logic        checksum_err_nxt, framing_err_nxt, timeout_err_nxt;
    logic        realign, sample, pid_ok;

    function automatic logic [7:0] add_carry(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7:0] + {7'd0, s[8]};
    endfunction

    // A falling edge while hunting for a break or start bit defines bit phase 0.
    assign realign = sdi_prev && !sdi && (state == S_IDLE || state == S_WAIT_START);
    assign cnt_cur = realign ? '0 : bit_cnt;
    assign sample  = (cnt_cur == BCW'(HALF_BIT));
    assign bit_cnt_nxt = (cnt_cur == BCW'(CLKS_PER_BIT - 1)) ? '0 : cnt_cur + 1'b1;

    assign pid_ok = (shreg[6] == (shreg[0] ^ shreg[1] ^ shreg[2] ^ shreg[4])) &&
                    (shreg[7] == ~(shreg[1] ^ shreg[3] ^ shreg[4] ^ shreg[5]));

    assign rx_busy = (state != S_IDLE);

    always_comb begin
        state_nxt        = state;
        field_nxt        = field;
        brk_cnt_nxt      = brk_cnt;
        to_cnt_nxt       = to_cnt;
        bit_idx_nxt      = bit_idx;
        byte_idx_nxt     = byte_idx;
        shreg_nxt        = shreg;
        sum_nxt          = sum;
        data_buf_nxt     = data_buf;
        pid_nxt          = pid_out;
        data_nxt         = data_out;
        pid_valid_nxt    = 1'b0;
        frame_valid_nxt  = 1'b0;
        sync_err_nxt     = 1'b0;
        parity_err_nxt   = 1'b0;
        checksum_err_nxt = 1'b0;
        framing_err_nxt  = 1'b0;
        timeout_err_nxt  = 1'b0;
        if (sample) begin
            case (state)
                S_IDLE: begin
                    if (sdi) begin
                        brk_cnt_nxt = '0;
                    end else if (brk_cnt == BKW'(BREAK_BITS - 1)) begin
                        state_nxt    = S_BREAK;
                        brk_cnt_nxt  = '0;
                        sum_nxt      = 8'h00;
                        data_buf_nxt = '0;
                    end else begin
                        brk_cnt_nxt = brk_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (sdi) begin
                        state_nxt  = S_WAIT_START;
                        field_nxt  = F_SYNC;
                        to_cnt_nxt = '0;
                    end
                end
                S_WAIT_START: begin
                    if (!sdi) begin
                        state_nxt   = S_SHIFT;
                        bit_idx_nxt = '0;
                    end else if (to_cnt == TOW'(IDLE_TIMEOUT - 1)) begin
                        timeout_err_nxt = 1'b1;
                        state_nxt       = S_IDLE;
                    end else begin
                        to_cnt_nxt = to_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    shreg_nxt = {sdi, shreg[7:1]};
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
                    else bit_idx_nxt = bit_idx + 1'b1;
                end
                S_STOP: begin
                    if (!sdi) begin
                        framing_err_nxt = 1'b1;
                        state_nxt       = S_IDLE;
                    end else begin
                        state_nxt  = S_WAIT_START;
                        to_cnt_nxt = '0;
                        case (field)
                            F_SYNC: begin
                                if (shreg != 8'h55) begin
                                    sync_err_nxt = 1'b1;
                                    state_nxt    = S_IDLE;
                                end else begin
                                    field_nxt = F_PID;
                                end
                            end
                            F_PID: begin
                                if (!pid_ok) begin
                                    parity_err_nxt = 1'b1;
                                    state_nxt      = S_IDLE;
                                end else begin
                                    pid_nxt       = shreg[5:0];
                                    pid_valid_nxt = 1'b1;
                                    field_nxt     = F_DATA;
                                    byte_idx_nxt  = '0;
`ifdef LIN_ENHANCED_CHECKSUM_EN
                                    sum_nxt = shreg;
`else
                                    sum_nxt = 8'h00;
`endif
                                end
                            end
                            F_DATA: begin
                                sum_nxt = add_carry(sum, shreg);
                                data_buf_nxt[8*byte_idx +: 8] = shreg;
                                if (byte_idx == 3'(DATA_BYTES - 1)) field_nxt = F_CHECKSUM;
                                else byte_idx_nxt = byte_idx + 1'b1;
                            end
                            F_CHECKSUM: begin
                                // Payload is only published once the checksum agrees.
                                if (shreg == ~sum) begin
                                    frame_valid_nxt = 1'b1;
                                    data_nxt        = data_buf;
                                end else begin
                                    checksum_err_nxt = 1'b1;
                                end
                                state_nxt = S_IDLE;
                            end
                        endcase
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            field        <= F_SYNC;
            sdi_prev     <= 1'b1;
            bit_cnt      <= '0;
            brk_cnt      <= '0;
            to_cnt       <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            sum          <= '0;
            data_buf     <= '0;
            pid_out      <= '0;
            data_out     <= '0;
            pid_valid    <= 1'b0;
            frame_valid  <= 1'b0;
            sync_err     <= 1'b0;
            parity_err   <= 1'b0;
            checksum_err <= 1'b0;
            framing_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            field        <= field_nxt;
            sdi_prev     <= sdi;
            bit_cnt      <= bit_cnt_nxt;
            brk_cnt      <= brk_cnt_nxt;
            to_cnt       <= to_cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            byte_idx     <= byte_idx_nxt;
            shreg        <= shreg_nxt;
            sum          <= sum_nxt;
            data_buf     <= data_buf_nxt;
            pid_out      <= pid_nxt;
            data_out     <= data_nxt;
            pid_valid    <= pid_valid_nxt;
            frame_valid  <= frame_valid_nxt;
            sync_err     <= sync_err_nxt;
            parity_err   <= parity_err_nxt;
            checksum_err <= checksum_err_nxt;
            framing_err  <= framing_err_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end
endmodule

// File: tb/tb_lin_frame_rx.sv
// Directed bench for lin_frame_rx: one-clock-per-bit instance plus a 16-clocks-per-bit instance.
module tb_lin_frame_rx;
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rstn, sdi, sdi16;
    logic [5:0]  pid_out, pid16;
    logic [63:0] data_out, data16;
    logic        pid_valid, frame_valid, sync_err, parity_err, checksum_err, framing_err, timeout_err, rx_busy;
    logic        pv16, fv16, se16, pe16, ce16, fe16, te16, busy16;

    lin_frame_rx #(.CLKS_PER_BIT(1)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .sdi(sdi), .pid_out(pid_out), .pid_valid(pid_valid),
        .data_out(data_out), .frame_valid(frame_valid), .sync_err(sync_err), .parity_err(parity_err),
        .checksum_err(checksum_err), .framing_err(framing_err), .timeout_err(timeout_err), .rx_busy(rx_busy));

    lin_frame_rx #(.CLKS_PER_BIT(16)) dut16 (
        .sys_clk(sys_clk), .rstn(rstn), .sdi(sdi16), .pid_out(pid16), .pid_valid(pv16),
        .data_out(data16), .frame_valid(fv16), .sync_err(se16), .parity_err(pe16),
        .checksum_err(ce16), .framing_err(fe16), .timeout_err(te16), .rx_busy(busy16));

`ifdef LIN_ENHANCED_CHECKSUM_EN
    localparam logic [7:0] CHK_A  = 8'h8B;
    localparam logic [7:0] CHK_FF = 8'hAF;
`else
    localparam logic [7:0] CHK_A  = 8'hDB;
    localparam logic [7:0] CHK_FF = 8'h00;
`endif
    localparam logic [63:0] DATA_A  = 64'h0102030405060708;
    localparam logic [63:0] DATA_FF = 64'hFFFF_FFFF_FFFF_FFFF;

    int vectors = 0;
    int miscompares = 0;

    // Pulse counters, written only by this monitor.
    int n_pv = 0, n_fv = 0, n_se = 0, n_pe = 0, n_ce = 0, n_fe = 0, n_te = 0, m_fv = 0, m_err = 0;
    always @(negedge sys_clk) begin
        if (pid_valid)    n_pv++;
        if (frame_valid)  n_fv++;
        if (sync_err)     n_se++;
        if (parity_err)   n_pe++;
        if (checksum_err) n_ce++;
        if (framing_err)  n_fe++;
        if (timeout_err)  n_te++;
        if (fv16) m_fv++;
        if (se16 || pe16 || ce16 || fe16 || te16) m_err++;
    end

    int b_pv, b_fv, b_se, b_pe, b_ce, b_fe, b_te, b_mfv, b_merr;

    function automatic int tot_err();
        return n_se + n_pe + n_ce + n_fe + n_te;
    endfunction

    task automatic snap();
        b_pv = n_pv; b_fv = n_fv; b_se = n_se; b_pe = n_pe; b_ce = n_ce;
        b_fe = n_fe; b_te = n_te; b_mfv = m_fv; b_merr = m_err;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b, input bit slow);
        if (slow) begin
            sdi16 = b;
            repeat (16) @(negedge sys_clk);
        end else begin
            sdi = b;
            @(negedge sys_clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic stop, input bit slow);
        send_bit(1'b0, slow);
        for (int i = 0; i < 8; i++) send_bit(v[i], slow);
        send_bit(stop, slow);
    endtask

    task automatic send_break(input int n, input bit slow);
        for (int i = 0; i < n; i++) send_bit(1'b0, slow);
        send_bit(1'b1, slow);
    endtask

    task automatic send_frame(input int brk, input logic [7:0] pid, input logic [63:0] d,
                              input logic [7:0] chk, input bit slow);
        send_break(brk, slow);
        send_byte(8'h55, 1'b1, slow);
        send_byte(pid, 1'b1, slow);
        for (int i = 0; i < 8; i++) send_byte(d[8*i +: 8], 1'b1, slow);
        send_byte(chk, 1'b1, slow);
    endtask

    initial begin
        rstn = 1'b0; sdi = 1'b1; sdi16 = 1'b1;
        tick(3);
        check("reset_pid_out", 64'(pid_out), 64'h0);
        check("reset_data_out", data_out, 64'h0);
        check("reset_flags", 64'({pid_valid, frame_valid, sync_err, parity_err, checksum_err,
                                  framing_err, timeout_err, rx_busy}), 64'h0);
        rstn = 1'b1;
        tick(4);

        // Good frame, with exact-cycle checks on break qualification and pulses.
        snap();
        for (int i = 0; i < 13; i++) send_bit(1'b0, 1'b0);
        check("busy_after_13_zeros", 64'(rx_busy), 64'h1);
        send_bit(1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h50, 1'b1, 1'b0);
        check("pid_valid_pulse", 64'(pid_valid), 64'h1);
        check("pid_out", 64'(pid_out), 64'h10);
        for (int i = 0; i < 8; i++) send_byte(DATA_A[8*i +: 8], 1'b1, 1'b0);
        send_byte(CHK_A, 1'b1, 1'b0);
        check("frame_valid_latency", 64'(frame_valid), 64'h1);
        check("data_out_a", data_out, DATA_A);
        check("busy_after_frame", 64'(rx_busy), 64'h0);
        tick(1);
        check("frame_valid_one_cycle", 64'(frame_valid), 64'h0);
        tick(2);
        check("good_fv_count", 64'(n_fv - b_fv), 64'h1);
        check("good_err_count", 64'(tot_err() - (b_se + b_pe + b_ce + b_fe + b_te)), 64'h0);

        // All-0xFF payload exercises end-around carry.
        snap();
        send_frame(13, 8'h50, DATA_FF, CHK_FF, 1'b0);
        tick(3);
        check("ff_fv_count", 64'(n_fv - b_fv), 64'h1);
        check("ff_data_out", data_out, DATA_FF);

        // Wrong checksum: error pulse, payload not published.
        snap();
        send_frame(13, 8'h50, DATA_A, 8'hDA, 1'b0);
        tick(3);
        check("badchk_ce_count", 64'(n_ce - b_ce), 64'h1);
        check("badchk_fv_count", 64'(n_fv - b_fv), 64'h0);
        check("badchk_data_kept", data_out, DATA_FF);

        // 12-zero pulse is not a break.
        snap();
        for (int i = 0; i < 12; i++) send_bit(1'b0, 1'b0);
        check("busy_after_12_zeros", 64'(rx_busy), 64'h0);
        send_bit(1'b1, 1'b0);
        tick(40);
        check("short_break_busy", 64'(rx_busy), 64'h0);
        check("short_break_errs", 64'(tot_err() - (b_se + b_pe + b_ce + b_fe + b_te)), 64'h0);

        // Bad sync byte.
        snap();
        send_break(13, 1'b0);
        send_byte(8'h54, 1'b1, 1'b0);
        tick(3);
        check("sync_err_count", 64'(n_se - b_se), 64'h1);
        check("sync_err_busy", 64'(rx_busy), 64'h0);

        // Bad PID parity.
        snap();
        send_break(13, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        tick(3);
        check("parity_err_count", 64'(n_pe - b_pe), 64'h1);
        check("parity_pv_count", 64'(n_pv - b_pv), 64'h0);

        // Data byte with a dominant stop bit.
        snap();
        send_break(13, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h50, 1'b1, 1'b0);
        send_byte(8'h08, 1'b0, 1'b0);
        sdi = 1'b1;
        tick(3);
        check("framing_err_count", 64'(n_fe - b_fe), 64'h1);
        check("framing_total_errs", 64'(tot_err() - (b_se + b_pe + b_ce + b_fe + b_te)), 64'h1);

        // Line idles after the PID: timeout on the 32nd recessive bit.
        snap();
        send_break(13, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h50, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) send_bit(1'b1, 1'b0);
        check("busy_before_timeout", 64'(rx_busy), 64'h1);
        send_bit(1'b1, 1'b0);
        check("timeout_err_pulse", 64'(timeout_err), 64'h1);
        check("busy_after_timeout", 64'(rx_busy), 64'h0);
        send_frame(20, 8'h50, DATA_A, CHK_A, 1'b0);
        tick(3);
        check("long_break_fv_count", 64'(n_fv - b_fv), 64'h1);
        check("long_break_data", data_out, DATA_A);
        check("timeout_total_errs", 64'(tot_err() - (b_se + b_pe + b_ce + b_fe + b_te)), 64'h1);

        // 16 clocks per bit instance.
        snap();
        send_frame(13, 8'h50, DATA_FF, CHK_FF, 1'b1);
        tick(20);
        check("cpb16_fv_count", 64'(m_fv - b_mfv), 64'h1);
        check("cpb16_err_count", 64'(m_err - b_merr), 64'h0);
        check("cpb16_data", data16, DATA_FF);
        check("cpb16_pid", 64'(pid16), 64'h10);

        // Reset in the middle of the data bytes.
        send_break(13, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h50, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(DATA_A[8*i +: 8], 1'b1, 1'b0);
        check("busy_before_reset", 64'(rx_busy), 64'h1);
        rstn = 1'b0;
        #1;
        check("midreset_pid_out", 64'(pid_out), 64'h0);
        check("midreset_data_out", data_out, 64'h0);
        check("midreset_flags", 64'({pid_valid, frame_valid, sync_err, parity_err, checksum_err,
                                     framing_err, timeout_err, rx_busy}), 64'h0);
        sdi = 1'b1;
        tick(2);
        rstn = 1'b1;
        tick(3);
        snap();
        send_frame(13, 8'h50, DATA_A, CHK_A, 1'b0);
        tick(3);
        check("post_reset_fv_count", 64'(n_fv - b_fv), 64'h1);
        check("post_reset_data", data_out, DATA_A);
        check("post_reset_pid", 64'(pid_out), 64'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
